// File: rtl/sh_mem_rr_arbiter_pkg.sv
// Shared definitions for the shared-memory round-robin arbiter: command encodings
// and default sizes.
package sh_mem_rr_arbiter_pkg;

  localparam int unsigned DefaultNumCores  = 4;
  localparam int unsigned DefaultAddrSize  = 8;
  localparam int unsigned DefaultRegSize   = 8;
  localparam int unsigned DefaultEnableSize = 2;

  typedef enum logic [1:0] {
    ENABLE_IDLE  = 2'b00,
    ENABLE_READ  = 2'b01,
    ENABLE_WRITE = 2'b10,
    ENABLE_RSVD  = 2'b11
  } enable_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: masks the in-flight requester, then selects the
// first eligible request at or above the pointer, wrapping to 0.
module rr_priority_picker #(
  parameter int unsigned NumCores = 4,
  parameter int unsigned IdW      = $clog2(NumCores)
) (
  input  logic [NumCores-1:0] req_i,
  input  logic                mask_v_i,
  input  logic [IdW-1:0]      mask_id_i,
  input  logic [IdW-1:0]      ptr_i,
  output logic                gnt_v_o,
  output logic [NumCores-1:0] gnt_oh_o,
  output logic [IdW-1:0]      gnt_id_o
);

  logic [NumCores-1:0] elig;

  always_comb begin
    elig = req_i;
    if (mask_v_i) begin
      elig[mask_id_i] = 1'b0;
    end
  end

  always_comb begin
    logic found;
    found    = 1'b0;
    gnt_v_o  = 1'b0;
    gnt_oh_o = '0;
    gnt_id_o = '0;
    for (int unsigned k = 0; k < NumCores; k++) begin
      int unsigned idx;
      idx = k + 32'(ptr_i);
      if (idx >= NumCores) begin
        idx = idx - NumCores;
      end
      if (!found && elig[idx]) begin
        found         = 1'b1;
        gnt_v_o       = 1'b1;
        gnt_id_o      = IdW'(idx);
        gnt_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sh_mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM among NUM_CORES cores;
// one access per cycle, one-cycle ready pulse, per-core read data held between reads.
module sh_mem_rr_arbiter
  import sh_mem_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CORES   = DefaultNumCores,
  parameter int unsigned ADDR_SIZE   = DefaultAddrSize,
  parameter int unsigned REG_SIZE    = DefaultRegSize,
  parameter int unsigned ENABLE_SIZE = DefaultEnableSize
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CORES*ENABLE_SIZE-1:0] enable_arb,
  input  logic [NUM_CORES*ADDR_SIZE-1:0]   addr_arb,
  input  logic [NUM_CORES*REG_SIZE-1:0]    wr_data_arb,
  output logic [NUM_CORES*REG_SIZE-1:0]    rd_data_arb,
  output logic [NUM_CORES-1:0]             ready_arb,
  output logic                             cmd_err,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_SIZE-1:0]             mem_addr,
  output logic [REG_SIZE-1:0]              mem_wdata,
  input  logic [REG_SIZE-1:0]              mem_rdata
);

  localparam int unsigned IdW = $clog2(NUM_CORES);

  logic [NUM_CORES-1:0]               req;
  logic                               rsvd_seen;
  logic                               gnt_v;
  logic [NUM_CORES-1:0]               gnt_oh;
  logic [IdW-1:0]                     gnt_id;
  logic [1:0]                         gnt_cmd;

  logic                               inflight_v_q, inflight_v_d;
  logic [IdW-1:0]                     inflight_id_q, inflight_id_d;
  logic                               inflight_rd_q, inflight_rd_d;
  logic [IdW-1:0]                     rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0][REG_SIZE-1:0] hold_q, hold_d;
  logic                               cmd_err_q, cmd_err_d;

  // Requests are suppressed during reset so every output reads 0 while it is high.
  always_comb begin
    req       = '0;
    rsvd_seen = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      logic [1:0] cmd;
      cmd    = enable_arb[i*ENABLE_SIZE +: 2];
      req[i] = !reset && (cmd == ENABLE_READ || cmd == ENABLE_WRITE);
      if (cmd == ENABLE_RSVD) begin
        rsvd_seen = 1'b1;
      end
    end
  end

  rr_priority_picker #(
    .NumCores (NUM_CORES),
    .IdW      (IdW)
  ) u_picker (
    .req_i     (req),
    .mask_v_i  (inflight_v_q),
    .mask_id_i (inflight_id_q),
    .ptr_i     (rr_ptr_q),
    .gnt_v_o   (gnt_v),
    .gnt_oh_o  (gnt_oh),
    .gnt_id_o  (gnt_id)
  );

  always_comb begin
    gnt_cmd   = enable_arb[32'(gnt_id)*ENABLE_SIZE +: 2];
    mem_en    = gnt_v;
    mem_we    = gnt_v && (gnt_cmd == ENABLE_WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_v) begin
      mem_addr  = addr_arb[32'(gnt_id)*ADDR_SIZE +: ADDR_SIZE];
      mem_wdata = wr_data_arb[32'(gnt_id)*REG_SIZE +: REG_SIZE];
    end
  end

  always_comb begin
    inflight_v_d  = gnt_v;
    inflight_id_d = gnt_id;
    inflight_rd_d = gnt_v && (gnt_cmd == ENABLE_READ);
    rr_ptr_d      = rr_ptr_q;
    if (gnt_v) begin
      rr_ptr_d = (gnt_id == IdW'(NUM_CORES - 1)) ? '0 : gnt_id + 1'b1;
    end
    hold_d = hold_q;
    if (inflight_v_q && inflight_rd_q) begin
      hold_d[inflight_id_q] = mem_rdata;
    end
    cmd_err_d = cmd_err_q | rsvd_seen;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_v_q  <= 1'b0;
      inflight_id_q <= '0;
      inflight_rd_q <= 1'b0;
      rr_ptr_q      <= '0;
      hold_q        <= '0;
      cmd_err_q     <= 1'b0;
    end else begin
      inflight_v_q  <= inflight_v_d;
      inflight_id_q <= inflight_id_d;
      inflight_rd_q <= inflight_rd_d;
      rr_ptr_q      <= rr_ptr_d;
      hold_q        <= hold_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  // Read responses bypass the SRAM output so data is visible in the ready cycle.
  always_comb begin
    ready_arb   = '0;
    rd_data_arb = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      rd_data_arb[i*REG_SIZE +: REG_SIZE] = hold_q[i];
    end
    if (inflight_v_q) begin
      ready_arb[inflight_id_q] = 1'b1;
      if (inflight_rd_q) begin
        rd_data_arb[32'(inflight_id_q)*REG_SIZE +: REG_SIZE] = mem_rdata;
      end
    end
  end

  assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_sh_mem_rr_arbiter.sv
// Directed self-checking bench for sh_mem_rr_arbiter with a 1-cycle-read SRAM model.
module tb_sh_mem_rr_arbiter;
  import sh_mem_rr_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int RW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*2-1:0]  enable_arb;
  logic [N*AW-1:0] addr_arb;
  logic [N*RW-1:0] wr_data_arb;
  logic [N*RW-1:0] rd_data_arb;
  logic [N-1:0]    ready_arb;
  logic            cmd_err;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [RW-1:0]   mem_wdata;
  logic [RW-1:0]   mem_rdata;

  logic [RW-1:0]   sram [256];

  int n_cmp = 0;
  int n_err = 0;

  sh_mem_rr_arbiter #(
    .NUM_CORES   (N),
    .ADDR_SIZE   (AW),
    .REG_SIZE    (RW),
    .ENABLE_SIZE (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable_arb  (enable_arb),
    .addr_arb    (addr_arb),
    .wr_data_arb (wr_data_arb),
    .rd_data_arb (rd_data_arb),
    .ready_arb   (ready_arb),
    .cmd_err     (cmd_err),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic [1:0] cmd, input logic [7:0] a,
                          input logic [7:0] d);
    enable_arb[i*2 +: 2]   = cmd;
    addr_arb[i*AW +: AW]   = a;
    wr_data_arb[i*RW +: RW] = d;
  endtask

  function automatic logic [RW-1:0] rdslice(input int i);
    return rd_data_arb[i*RW +: RW];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    enable_arb  = '0;
    addr_arb    = '0;
    wr_data_arb = '0;
    mem_rdata   = '0;
    for (int i = 0; i < 256; i++) sram[i] = '0;
    #1;
    check("rst ready", ready_arb, 0);
    check("rst mem_en", mem_en, 0);
    check("rst rd_data", rd_data_arb, 0);
    check("rst cmd_err", cmd_err, 0);
    tick();
    reset = 1'b0;

    // Core 2 writes 0x5A to 0x10, then reads it back.
    set_core(2, ENABLE_WRITE, 8'h10, 8'h5A);
    #1;
    check("s1 wr mem_en", mem_en, 1);
    check("s1 wr mem_we", mem_we, 1);
    check("s1 wr addr", mem_addr, 8'h10);
    check("s1 wr wdata", mem_wdata, 8'h5A);
    check("s1 wr no ready", ready_arb, 0);
    tick();
    check("s1 wr ready", ready_arb, 4'b0100);
    check("s1 masked", mem_en, 0);
    tick();
    set_core(2, ENABLE_READ, 8'h10, 8'h00);
    #1;
    check("s1 rd mem_en", mem_en, 1);
    check("s1 rd mem_we", mem_we, 0);
    check("s1 rd addr", mem_addr, 8'h10);
    tick();
    check("s1 rd ready", ready_arb, 4'b0100);
    check("s1 rd data", rdslice(2), 8'h5A);
    set_core(2, ENABLE_IDLE, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) tick();
    check("s1 hold", rdslice(2), 8'h5A);
    check("s1 idle ready", ready_arb, 0);
    check("s1 idle mem_en", mem_en, 0);

    // Reset clears hold; then all four cores read continuously.
    reset = 1'b1;
    #1;
    check("s2 rst hold", rdslice(2), 8'h00);
    for (int i = 0; i < N; i++) begin
      sram[8'h20 + i] = 8'(8'h30 + i);
      set_core(i, ENABLE_READ, 8'(8'h20 + i), 8'h00);
    end
    #1;
    check("s2 rst mem_en", mem_en, 0);
    tick();
    reset = 1'b0;
    #1;
    for (int c = 0; c < 8; c++) begin
      int g;
      int p;
      g = c % N;
      check($sformatf("s2 c%0d mem_en", c), mem_en, 1);
      check($sformatf("s2 c%0d addr", c), mem_addr, 32'(8'h20 + g));
      if (c > 0) begin
        p = (c - 1) % N;
        check($sformatf("s2 c%0d ready", c), ready_arb, 32'(1) << p);
        check($sformatf("s2 c%0d data", c), rdslice(p), 32'(8'h30 + p));
      end
      tick();
    end
    for (int i = 0; i < N; i++) set_core(i, ENABLE_IDLE, 8'h00, 8'h00);
    #1;
    check("s2 last ready", ready_arb, 4'b1000);
    check("s2 last data", rdslice(3), 8'h33);
    check("s2 idle mem_en", mem_en, 0);

    // Move pointer to 2 with a lone core-1 write, then cores 1 and 3 contend.
    tick();
    set_core(1, ENABLE_WRITE, 8'h40, 8'h11);
    #1;
    check("s3 wr addr", mem_addr, 8'h40);
    check("s3 wr we", mem_we, 1);
    tick();
    check("s3 wr ready", ready_arb, 4'b0010);
    set_core(1, ENABLE_IDLE, 8'h00, 8'h00);
    tick();
    set_core(1, ENABLE_READ, 8'h40, 8'h00);
    set_core(3, ENABLE_READ, 8'h23, 8'h00);
    #1;
    check("s3 first addr", mem_addr, 8'h23);
    check("s3 first we", mem_we, 0);
    tick();
    check("s3 ready3", ready_arb, 4'b1000);
    check("s3 data3", rdslice(3), 8'h33);
    check("s3 second addr", mem_addr, 8'h40);
    set_core(3, ENABLE_IDLE, 8'h00, 8'h00);
    tick();
    check("s3 ready1", ready_arb, 4'b0010);
    check("s3 data1", rdslice(1), 8'h11);
    set_core(1, ENABLE_IDLE, 8'h00, 8'h00);

    // Reserved command sets the sticky error flag.
    tick();
    set_core(0, ENABLE_RSVD, 8'h00, 8'h00);
    #1;
    check("s4 mem_en", mem_en, 0);
    check("s4 ready", ready_arb, 0);
    check("s4 err before edge", cmd_err, 0);
    tick();
    check("s4 err set", cmd_err, 1);
    check("s4 mem_en2", mem_en, 0);
    check("s4 ready2", ready_arb, 0);
    set_core(0, ENABLE_IDLE, 8'h00, 8'h00);
    tick();
    check("s4 err sticky", cmd_err, 1);

    // Reset in the response cycle of a core-1 read; the read is re-issued.
    set_core(1, ENABLE_READ, 8'h40, 8'h00);
    #1;
    check("s5 grant", mem_en, 1);
    check("s5 addr", mem_addr, 8'h40);
    tick();
    reset = 1'b1;
    #1;
    check("s5 rst ready", ready_arb, 0);
    check("s5 rst rd_data", rd_data_arb, 0);
    check("s5 rst mem_en", mem_en, 0);
    check("s5 rst cmd_err", cmd_err, 0);
    tick();
    reset = 1'b0;
    #1;
    check("s5 regrant", mem_en, 1);
    check("s5 regrant addr", mem_addr, 8'h40);
    tick();
    check("s5 ready", ready_arb, 4'b0010);
    check("s5 data", rdslice(1), 8'h11);
    set_core(1, ENABLE_IDLE, 8'h00, 8'h00);

    // Pointer back to 0, then same-address write (core 0) and read (core 1).
    tick();
    set_core(3, ENABLE_READ, 8'h23, 8'h00);
    #1;
    check("s6 c3 addr", mem_addr, 8'h23);
    tick();
    check("s6 c3 ready", ready_arb, 4'b1000);
    set_core(3, ENABLE_IDLE, 8'h00, 8'h00);
    tick();
    set_core(0, ENABLE_WRITE, 8'h50, 8'hAA);
    set_core(1, ENABLE_READ, 8'h50, 8'h00);
    #1;
    check("s6 wr first we", mem_we, 1);
    check("s6 wr addr", mem_addr, 8'h50);
    check("s6 wr data", mem_wdata, 8'hAA);
    tick();
    check("s6 wr ready", ready_arb, 4'b0001);
    check("s6 rd we", mem_we, 0);
    check("s6 rd addr", mem_addr, 8'h50);
    set_core(0, ENABLE_IDLE, 8'h00, 8'h00);
    tick();
    check("s6 rd ready", ready_arb, 4'b0010);
    check("s6 rd data", rdslice(1), 8'hAA);
    check("s6 wr no hold", rdslice(0), 8'h00);
    set_core(1, ENABLE_IDLE, 8'h00, 8'h00);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sh_mem_rr_arbiter.md
# sh_mem_rr_arbiter

Round-robin arbiter that shares one single-port synchronous shared-memory bank between `NUM_CORES` core memory ports. It sits between the per-core `enable/addr/wr_data/rd_data/ready` buses of the core array and the SRAM macro. It issues at most one memory access per cycle, which sustains one access per cycle across distinct cores. Each core receives a one-cycle `ready` pulse and holds its read data until its next read completes.

## Interface
Parameters:
- `NUM_CORES`, 4: number of requesting cores (≥2).
- `ADDR_SIZE`, 8: word-address width.
- `REG_SIZE`, 8: data word width.
- `ENABLE_SIZE`, 2: per-core command width (fixed at 2).

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `enable_arb` in NUM_CORES*2: per-core command, slice i = core i. `00` idle, `01` read, `10` write, `11` reserved.
- `addr_arb` in NUM_CORES*ADDR_SIZE: per-core address.
- `wr_data_arb` in NUM_CORES*REG_SIZE: per-core write data.
- `rd_data_arb` out NUM_CORES*REG_SIZE: per-core read data.
- `ready_arb` out NUM_CORES: per-core completion pulse.
- `cmd_err` out 1: sticky; set when a reserved command `11` is seen.
- `mem_en` out 1: SRAM access strobe.
- `mem_we` out 1: SRAM write enable (valid when `mem_en`).
- `mem_addr` out ADDR_SIZE: SRAM address.
- `mem_wdata` out REG_SIZE: SRAM write data.
- `mem_rdata` in REG_SIZE: SRAM read data, valid the cycle after a read strobe.

## Operation
- A request is level-sensitive. Core i requests when its slice is `01` or `10`. It must hold command, address and data stable until it sees `ready_arb[i]`.
- `11` is not a request. It sets `cmd_err` on the next edge; `cmd_err` clears only on reset.
- Eligible set = requesting cores minus the in-flight core (the one granted last cycle, when `inflight_v`=1).
- Grant: the first eligible core at or after pointer `rr_ptr`, scanning upward with wrap from NUM_CORES-1 to 0.
  - On a grant g: `rr_ptr` ← (g+1) mod NUM_CORES.
  - With no grant, `rr_ptr` holds.
- Memory drive is combinational from the grant:
  - `mem_en`=1.
  - `mem_we`=1 for write, 0 for read.
  - `mem_addr` and `mem_wdata` come from slice g.
  - With no grant, `mem_en`=0 and the other mem outputs are 0.
- In-flight register: `inflight_v` ← grant valid; `inflight_id` ← g; `inflight_rd` ← read.
- Response, in the cycle where `inflight_v`=1:
  - `ready_arb[inflight_id]`=1; all other ready bits are 0.
  - If `inflight_rd`, `rd_data_arb[inflight_id]` = `mem_rdata` (bypass), and `hold[inflight_id]` ← `mem_rdata` at the end of that cycle.
  - Otherwise, `rd_data_arb[i]` = `hold[i]`.
- Writes never change `hold`.
- Reset (asynchronous, any time, including mid-access): `inflight_v`=0, `rr_ptr`=0, all `hold`=0, `cmd_err`=0.
  - All outputs read 0 while `reset` is high.
  - An access whose strobe preceded reset gets no `ready`. The requester re-issues it.

## Timing
- Access latency: core grant in cycle t → `ready` pulse in cycle t+1, exactly one cycle wide. Read data is valid in t+1 and held until that core's next read response.
- The core drops or changes its command at the edge ending t+1.
- Because of the in-flight mask, a core cannot be granted in t+1. A continuously requesting core is therefore served at most every 2 cycles.
- Peak throughput: 1 access per cycle when ≥2 cores are requesting.
- Worst-case wait for a core from first request to grant: NUM_CORES cycles.
- Back-to-back accesses to the same address from different cores are ordered by grant order. A read granted the cycle after a write to the same address returns the new data (SRAM write-then-read ordering).

## Structure
- Command encodings (`ENABLE_IDLE/READ/WRITE/RSVD`) and default sizes go in the shared definitions header included by the core and memory blocks.
- One sub-module, `rr_priority_picker`, contains the masked request vector plus the pointer → one-hot grant and binary id logic. It is purely combinational.
- The in-flight register, pointer, `hold` array and `cmd_err` live in the top module.

## Test plan
All scenarios use NUM_CORES=4, ADDR=8, REG=8, and an SRAM model with 1-cycle read.
- Single write, then read: core 2 writes 0x5A to 0x10, then reads 0x10 → `mem_we`=1 in the grant cycle, `ready_arb`=0100 in the next cycle, read response returns 0x5A on slice 2. `hold[2]`=0x5A persists for ≥5 idle cycles.
- All four cores read continuously from reset → grant order 0,1,2,3,0,…, one `mem_en` every cycle, each core's `ready` every 2 cycles or more, and no core ever granted in consecutive cycles.
- Cores 1 and 3 request while `rr_ptr`=2 → core 3 is granted first, `rr_ptr` becomes 0, core 1 is granted next cycle.
- Core 0 drives `11` → no `mem_en`, no `ready`, `cmd_err`=1 from the next edge and still 1 after the command returns to `00`.
- `reset` asserted in the cycle after core 1's read grant → `ready_arb`=0000 immediately and `rd_data_arb`=0. After release, core 1 holding its request is granted first and gets correct data.
- Core 0 writes 0xAA and core 1 reads the same address, both raised together with `rr_ptr`=0 → the write is granted first and core 1 reads 0xAA.
